// File: rtl/gcd_requester_pkg.sv
// Shared definitions for the GCD requester: FSM state encoding and parameter defaults.
package gcd_requester_pkg;

  localparam int GCD_WIDTH_DEF      = 32;
  localparam int GCD_FIFO_DEPTH_DEF = 4;
  localparam int GCD_TIMEOUT_DEF    = 4096;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } gcd_state_e;

endpackage

// File: rtl/gcd_req_fifo.sv
// Synchronous FIFO for operand pairs; pointers carry an extra wrap bit for full/empty.
module gcd_req_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          do_push_s, do_pop_s;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full queue is honoured only when the head leaves in the same cycle.
  always_comb begin
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {(AW + 1){1'b0}};
      rd_ptr_q <= {(AW + 1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/gcd_requester.sv
// Queues operand pairs, drives an external GCD core one request at a time, and
// holds each result (or a timeout marker) until the consumer accepts it.
module gcd_requester
  import gcd_requester_pkg::*;
#(
  parameter int WIDTH       = GCD_WIDTH_DEF,
  parameter int FIFO_DEPTH  = GCD_FIFO_DEPTH_DEF,
  parameter int TIMEOUT_CYC = GCD_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_x,
  input  logic [WIDTH-1:0] op_y,
  output logic [WIDTH-1:0] gcd_x,
  output logic [WIDTH-1:0] gcd_y,
  output logic             gcd_start,
  input  logic [WIDTH-1:0] gcd_result,
  input  logic             gcd_done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_timeout,
  output logic             busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};

  gcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] gcd_x_q, gcd_x_d, gcd_y_q, gcd_y_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             gcd_start_q, gcd_start_d;
  logic             res_valid_q, res_valid_d;
  logic             res_timeout_q, res_timeout_d;

  logic [2*WIDTH-1:0] head_s;
  logic [WIDTH-1:0]   head_x_s, head_y_s;
  logic               fifo_full_s, fifo_empty_s, push_s, pop_s;

  assign push_s   = op_valid & ~fifo_full_s;
  assign head_x_s = head_s[2*WIDTH-1:WIDTH];
  assign head_y_s = head_s[WIDTH-1:0];

  gcd_req_fifo #(
    .DW    (2 * WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata ({op_x, op_y}),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Next-state logic; the head stays queued until its result is accepted in HOLD.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    gcd_x_d       = gcd_x_q;
    gcd_y_d       = gcd_y_q;
    gcd_start_d   = 1'b0;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    res_timeout_d = res_timeout_q;
    pop_s         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fifo_empty_s) begin
          state_d = ST_IDLE;
        end else if ((head_x_s != W_ZERO) && (head_y_s != W_ZERO)) begin
          state_d     = ST_ISSUE;
          gcd_x_d     = head_x_s;
          gcd_y_d     = head_y_s;
          gcd_start_d = 1'b1;
        end else begin
          state_d       = ST_HOLD;
          res_valid_d   = 1'b1;
          res_data_d    = head_x_s | head_y_s;
          res_timeout_d = 1'b0;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = CNT_ZERO;
      end
      ST_WAIT: begin
        // cnt_q == 0 marks the first WAIT cycle, where a stale done is ignored.
        if (gcd_done && (cnt_q != CNT_ZERO)) begin
          state_d       = ST_HOLD;
          res_valid_d   = 1'b1;
          res_data_d    = gcd_result;
          res_timeout_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = ST_HOLD;
          res_valid_d   = 1'b1;
          res_data_d    = W_ZERO;
          res_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (res_ready) begin
          state_d       = ST_IDLE;
          pop_s         = 1'b1;
          res_valid_d   = 1'b0;
          res_timeout_d = 1'b0;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= CNT_ZERO;
      gcd_x_q       <= W_ZERO;
      gcd_y_q       <= W_ZERO;
      gcd_start_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= W_ZERO;
      res_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      gcd_x_q       <= gcd_x_d;
      gcd_y_q       <= gcd_y_d;
      gcd_start_q   <= gcd_start_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  assign op_ready    = ~fifo_full_s;
  assign busy        = (state_q != ST_IDLE) | ~fifo_empty_s;
  assign gcd_x       = gcd_x_q;
  assign gcd_y       = gcd_y_q;
  assign gcd_start   = gcd_start_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_timeout = res_timeout_q;

endmodule

// File: tb/tb_gcd_requester.sv
// Directed and randomized bench for gcd_requester with a behavioural GCD core and result scoreboard.
module tb_gcd_requester;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         op_valid = 1'b0;
  logic         op_ready;
  logic [W-1:0] op_x = 32'd0, op_y = 32'd0;
  logic [W-1:0] gcd_x, gcd_y;
  logic         gcd_start;
  logic [W-1:0] gcd_result = 32'd0;
  logic         gcd_done = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_data;
  logic         res_timeout;
  logic         busy;

  gcd_requester #(
    .WIDTH       (W),
    .FIFO_DEPTH  (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_x        (op_x),
    .op_y        (op_y),
    .gcd_x       (gcd_x),
    .gcd_y       (gcd_y),
    .gcd_start   (gcd_start),
    .gcd_result  (gcd_result),
    .gcd_done    (gcd_done),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_timeout (res_timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [W-1:0] d;
    logic         t;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a_in, input logic [W-1:0] b_in);
    logic [W-1:0] a, b, t;
    a = a_in;
    b = b_in;
    while (b != 32'd0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Behavioural core: answers core_lat cycles after a start; optionally leaves done asserted.
  int           core_lat = 5;
  int           core_cnt = 0;
  int           stale = 0;
  bit           core_on = 1'b1;
  bit           core_sticky = 1'b0;
  logic [W-1:0] core_res = 32'd0;

  always @(negedge clk) begin
    if (gcd_start === 1'b1 && core_on) begin
      core_cnt = core_lat;
      core_res = ref_gcd(gcd_x, gcd_y);
      if (core_sticky && gcd_done) stale = 1;
      else gcd_done = 1'b0;
    end else if (core_cnt > 0) begin
      core_cnt = core_cnt - 1;
      if (core_cnt == 0) begin
        gcd_done   = 1'b1;
        gcd_result = core_res;
      end else if (stale > 0) begin
        stale = stale - 1;
      end else begin
        gcd_done = 1'b0;
      end
    end else if (!core_sticky) begin
      gcd_done = 1'b0;
    end
  end

  int           starts = 0;
  int           run = 0;
  int           max_run = 0;
  logic [W-1:0] start_x = 32'd0, start_y = 32'd0;

  always @(negedge clk) begin
    if (gcd_start === 1'b1) begin
      starts  = starts + 1;
      run     = run + 1;
      start_x = gcd_x;
      start_y = gcd_y;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    if (x == 32'd0 || y == 32'd0) begin
      e.d = x | y; e.t = 1'b0;
    end else if (core_on) begin
      e.d = ref_gcd(x, y); e.t = 1'b0;
    end else begin
      e.d = 32'd0; e.t = 1'b1;
    end
    return e;
  endfunction

  task automatic push(input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    n = 0;
    op_x = x; op_y = y; op_valid = 1'b1;
    while (op_ready !== 1'b1 && n < 300) begin step(); n++; end
    check("push_ready", 32'(n < 300), 32'd1);
    if (n < 300) begin
      exp_q.push_back(model(x, y));
      step();
    end
    op_valid = 1'b0;
  endtask

  task automatic get_result(input string tag);
    int   n;
    exp_t e;
    n = 0;
    res_ready = 1'b1;
    while (res_valid !== 1'b1 && n < 300) begin step(); n++; end
    check({tag, "_wait"}, 32'(n < 300), 32'd1);
    if (n < 300) begin
      if (exp_q.size() == 0) begin
        check({tag, "_unexpected"}, 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check({tag, "_data"}, res_data, e.d);
        check({tag, "_timeout"}, 32'(res_timeout), 32'(e.t));
      end
      step();
    end
    res_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_data"}, res_data, 32'd0);
    check({tag, "_res_timeout"}, 32'(res_timeout), 32'd0);
    check({tag, "_gcd_start"}, 32'(gcd_start), 32'd0);
    check({tag, "_gcd_x"}, gcd_x, 32'd0);
    check({tag, "_gcd_y"}, gcd_y, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_op_ready"}, 32'(op_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, acc, n, cnt;
    logic [W-1:0] x, y, k;

    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Core path: (95,25) -> 5
    s0 = starts; max_run = 0;
    push(32'd95, 32'd25);
    get_result("r95_25");
    check("r95_starts", 32'(starts - s0), 32'd1);
    check("r95_gcd_x", start_x, 32'd95);
    check("r95_gcd_y", start_y, 32'd25);
    check("r95_held_x", gcd_x, 32'd95);
    check("start_width", 32'(max_run), 32'd1);

    // Bypass path: zero operands never start the core
    s0 = starts;
    push(32'd0, 32'd7);
    push(32'd12, 32'd0);
    push(32'd0, 32'd0);
    get_result("byp0_7");
    get_result("byp12_0");
    get_result("byp0_0");
    check("byp_starts", 32'(starts - s0), 32'd0);

    // Back-pressure: exactly FIFO_DEPTH pairs accepted while results are blocked
    res_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      k = 32'($urandom_range(1, 50));
      op_x = k * 32'($urandom_range(1, 200));
      op_y = k * 32'($urandom_range(1, 200));
      op_valid = 1'b1;
      if (op_ready === 1'b1) begin
        exp_q.push_back(model(op_x, op_y));
        acc++;
      end
      step();
    end
    op_valid = 1'b0;
    check("full_accepted", 32'(acc), 32'd4);
    check("full_op_ready", 32'(op_ready), 32'd0);
    for (int i = 0; i < 4; i++) get_result("drain");
    check("drain_busy", 32'(busy), 32'd0);

    // Randomized pairs, some with zero operands, random consumer delay
    for (int i = 0; i < 8; i++) begin
      k = 32'($urandom_range(1, 40));
      x = ($urandom_range(0, 4) == 0) ? 32'd0 : k * 32'($urandom_range(1, 300));
      y = ($urandom_range(0, 4) == 0) ? 32'd0 : k * 32'($urandom_range(1, 300));
      push(x, y);
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) step();
      get_result("rand");
    end

    // Timeout: core never answers; 1 ISSUE cycle + 16 WAIT cycles before HOLD
    core_on = 1'b0;
    push(32'd30, 32'd20);
    n = 0;
    while (gcd_start !== 1'b1 && n < 50) begin step(); n++; end
    check("to_start_seen", 32'(n < 50), 32'd1);
    cnt = 0;
    while (res_valid !== 1'b1 && cnt < 100) begin step(); cnt++; end
    check("to_latency", 32'(cnt), 32'd17);
    get_result("timeout");
    core_on = 1'b1;

    // Reset during WAIT with two pairs queued
    core_lat = 10;
    push(32'd9, 32'd6);
    push(32'd10, 32'd4);
    push(32'd14, 32'd21);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("midreset");
    exp_q.delete();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (res_valid === 1'b1 || gcd_start === 1'b1) cnt++;
      step();
    end
    check("midreset_quiet", 32'(cnt), 32'd0);
    core_lat = 5;
    push(32'd48, 32'd18);
    get_result("post_reset");

    // Stale done from the previous run must not be captured
    core_sticky = 1'b1;
    push(32'd21, 32'd14);
    get_result("sticky_first");
    check("sticky_done_high", 32'(gcd_done), 32'd1);
    push(32'd48, 32'd36);
    get_result("sticky_second");
    core_sticky = 1'b0;

    check("final_busy", 32'(busy), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
